// File: rtl/sram_stream_reader.sv
// Wishbone-controlled reader: streams COUNT words from SRAM starting at BASE
// out as bytes, LSB first, with valid/ready handshaking and a done interrupt.
module sram_stream_reader #(
  parameter int SRAM_ADDR_WD = 8,
  parameter int SRAM_DATA_WD = 32
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [1:0]              wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  input  logic [3:0]              wb_sel_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    sram_csb_o,
  output logic [SRAM_ADDR_WD-1:0] sram_addr_o,
  input  logic [SRAM_DATA_WD-1:0] sram_dout_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic                    irq_o
);

  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_ack;
  logic [31:0]             r_dat;
  logic                    r_start;
  logic                    r_abort;
  logic                    r_irq_en;
  logic                    r_done;
  logic [7:0]              r_base;
  logic [8:0]              r_count;
  logic [SRAM_ADDR_WD-1:0] r_cur_addr;
  logic [8:0]              r_remaining;
  logic [SRAM_DATA_WD-1:0] r_word;
  logic [1:0]              r_idx;

  logic        w_req;
  logic        w_wr;
  logic        w_busy;
  logic [31:0] w_rd_data;
  logic        w_set_done;
  logic        w_latch;
  logic        w_capture;
  logic        w_advance;
  logic        w_unused;

  assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr     = w_req & wb_we_i;
  assign w_busy   = (r_state != IDLE);
  assign w_unused = ^{wb_dat_i[31:9], wb_sel_i[3:2]};

  always_comb begin
    w_rd_data = 32'd0;
    case (wb_adr_i)
      2'd0:    w_rd_data = {29'd0, r_irq_en, 2'b00};
      2'd1:    w_rd_data = {30'd0, r_done, w_busy};
      2'd2:    w_rd_data = {24'd0, r_base};
      default: w_rd_data = {23'd0, r_count};
    endcase
  end

  // Register file: writes and read data land on the edge that raises ack, so
  // both are visible during the ack cycle; START/ABORT pulse in that cycle.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_ack    <= 1'b0;
      r_dat    <= 32'd0;
      r_start  <= 1'b0;
      r_abort  <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_base   <= 8'd0;
      r_count  <= 9'd0;
    end else begin
      r_ack   <= w_req;
      r_start <= w_wr && (wb_adr_i == 2'd0) && wb_sel_i[0] && wb_dat_i[0];
      r_abort <= w_wr && (wb_adr_i == 2'd0) && wb_sel_i[0] && wb_dat_i[1];
      if (w_req)
        r_dat <= w_rd_data;
      if (w_wr && (wb_adr_i == 2'd0) && wb_sel_i[0])
        r_irq_en <= wb_dat_i[2];
      if (w_wr && (wb_adr_i == 2'd2) && wb_sel_i[0])
        r_base <= wb_dat_i[7:0];
      if (w_wr && (wb_adr_i == 2'd3)) begin
        if (wb_sel_i[0]) r_count[7:0] <= wb_dat_i[7:0];
        if (wb_sel_i[1]) r_count[8]   <= wb_dat_i[8];
      end
      if (w_set_done)
        r_done <= 1'b1;
      else if (w_wr && (wb_adr_i == 2'd1) && wb_sel_i[0] && wb_dat_i[1])
        r_done <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // ABORT overrides every datapath update so nothing is captured or emitted
  // once it is seen.
  always_comb begin
    w_next     = r_state;
    w_set_done = 1'b0;
    w_latch    = 1'b0;
    w_capture  = 1'b0;
    w_advance  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_start) begin
          if (r_count == 9'd0) begin
            w_set_done = 1'b1;
          end else begin
            w_latch = 1'b1;
            w_next  = RD;
          end
        end
      end
      RD:  w_next = CAP;
      CAP: begin
        w_capture = 1'b1;
        w_next    = SEND;
      end
      default: begin
        if (tx_ready_i) begin
          w_advance = 1'b1;
          if (r_idx == 2'd3) begin
            if (r_remaining == 9'd1) begin
              w_next     = IDLE;
              w_set_done = 1'b1;
            end else begin
              w_next = RD;
            end
          end
        end
      end
    endcase
    if (r_abort && (r_state != IDLE)) begin
      w_next     = IDLE;
      w_set_done = 1'b1;
      w_latch    = 1'b0;
      w_capture  = 1'b0;
      w_advance  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr  <= '0;
      r_remaining <= 9'd0;
      r_word      <= '0;
      r_idx       <= 2'd0;
    end else begin
      if (w_latch) begin
        r_cur_addr  <= SRAM_ADDR_WD'(r_base);
        r_remaining <= r_count;
      end
      if (w_capture) begin
        r_word <= sram_dout_i;
        r_idx  <= 2'd0;
      end
      if (w_advance) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_remaining <= r_remaining - 9'd1;
          if (r_remaining != 9'd1)
            r_cur_addr <= r_cur_addr + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tx_data_o = 8'd0;
    case (r_idx)
      2'd0:    tx_data_o = r_word[7:0];
      2'd1:    tx_data_o = r_word[15:8];
      2'd2:    tx_data_o = r_word[23:16];
      default: tx_data_o = r_word[31:24];
    endcase
  end

  assign tx_valid_o  = (r_state == SEND);
  assign sram_csb_o  = (r_state != RD);
  assign sram_addr_o = r_cur_addr;
  assign wb_ack_o    = r_ack;
  assign wb_dat_o    = r_dat;
  assign irq_o       = r_done & r_irq_en;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader: expected bytes/addresses queued at
// stimulus time, observed ones recorded by a monitor, compared per scenario.
module tb_sram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] dat_i = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] dat_o;
  logic        ack;
  logic        csb;
  logic [7:0]  addr;
  logic [31:0] dout = 32'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        irq;

  logic [31:0] mem [256];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cycle = 0;
  logic [7:0]  exp_b[$], obs_b[$], exp_a[$], obs_a[$];
  int          obs_c[$];

  sram_stream_reader #(.SRAM_ADDR_WD(8), .SRAM_DATA_WD(32)) dut (
    .wb_clk_i(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .sram_csb_o(csb), .sram_addr_o(addr), .sram_dout_i(dout),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!csb) dout <= mem[addr];
  end

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      obs_b.push_back(tx_data);
      obs_c.push_back(cycle);
    end
    if (!csb) obs_a.push_back(addr);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = 4'hf;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL wb_write_ack: no ack for adr %0d, required ack", a);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    d = 32'hx;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hf;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; d = dat_o; break; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL wb_read_ack: no ack for adr %0d, required ack", a);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < 100; i++) begin
      wb_read(2'd1, s);
      if (!s[0]) break;
    end
    if (s[0]) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: BUSY still %0d, required 0", s[0]);
    end
  endtask

  task automatic wait_valid(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_valid) begin got = 1'b1; break; end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_valid_timeout: tx_valid 0, required 1", name);
    end
  endtask

  task automatic clear_obs();
    obs_b.delete(); obs_a.delete(); obs_c.delete();
    exp_b.delete(); exp_a.delete();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if ({csb, addr, tx_valid, tx_data, irq, ack, dat_o} !== {1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: csb=%b addr=%h valid=%b data=%h irq=%b ack=%b dat=%h, required csb=1 rest 0",
               csb, addr, tx_valid, tx_data, irq, ack, dat_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      wb_read(2'(a), r);
      n_chk++;
      if (r !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, required 00000000", a, r);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    logic [7:0]  e, o;
    clear_obs();
    mem[8'h10] = 32'h44332211;
    mem[8'h11] = 32'h88776655;
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) exp_b.push_back(8'(i * 8'h11));
    exp_a.push_back(8'h10); exp_a.push_back(8'h11);
    wb_write(2'd2, 32'h10);
    wb_write(2'd3, 32'd2);
    wb_write(2'd0, 32'h1);
    @(negedge clk);
    n_chk++;
    if (csb !== 1'b0 || addr !== 8'h10) begin
      n_fail++;
      $display("FAIL basic_csb_latency: csb=%b addr=%h, required csb=0 addr=10", csb, addr);
    end
    @(negedge clk);
    n_chk++;
    if (tx_valid !== 1'b0 || csb !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_cap_cycle: valid=%b csb=%b, required valid=0 csb=1", tx_valid, csb);
    end
    @(negedge clk);
    n_chk++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      n_fail++;
      $display("FAIL basic_first_byte: valid=%b data=%h, required valid=1 data=11", tx_valid, tx_data);
    end
    wait_idle();
    n_chk++;
    if (obs_c.size() < 5 || obs_c[1] != obs_c[0] + 1 || obs_c[4] != obs_c[3] + 3) begin
      n_fail++;
      $display("FAIL basic_spacing: %0d bytes stamped, required 1-cycle byte spacing and 3-cycle word gap",
               obs_c.size());
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      n_chk++;
      if (obs_b.size() == 0) begin
        n_fail++; $display("FAIL basic_byte: missing, required %h", e);
      end else begin
        o = obs_b.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL basic_byte: got %h, required %h", o, e); end
      end
    end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_chk++;
      if (obs_a.size() == 0) begin
        n_fail++; $display("FAIL basic_addr: missing, required %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL basic_addr: got %h, required %h", o, e); end
      end
    end
    n_chk++;
    if (obs_b.size() != 0 || obs_a.size() != 0) begin
      n_fail++;
      $display("FAIL basic_extra: %0d bytes %0d reads extra, required 0", obs_b.size(), obs_a.size());
    end
    wb_read(2'd1, r);
    n_chk++;
    if (r !== 32'h2) begin n_fail++; $display("FAIL basic_status: got %h, required 00000002", r); end
    wb_write(2'd1, 32'h2);
    wb_read(2'd1, r);
    n_chk++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL basic_w1c: got %h, required 00000000", r); end
  endtask

  task automatic test_wrap();
    logic [7:0] e, o;
    clear_obs();
    mem[8'hFF] = 32'hDDCCBBAA;
    mem[8'h00] = 32'h04030201;
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_a = '{8'hFF, 8'h00};
    wb_write(2'd2, 32'hFF);
    wb_write(2'd3, 32'd2);
    wb_write(2'd0, 32'h1);
    wait_idle();
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      n_chk++;
      if (obs_b.size() == 0) begin
        n_fail++; $display("FAIL wrap_byte: missing, required %h", e);
      end else begin
        o = obs_b.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL wrap_byte: got %h, required %h", o, e); end
      end
    end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_chk++;
      if (obs_a.size() == 0) begin
        n_fail++; $display("FAIL wrap_addr: missing, required %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL wrap_addr: got %h, required %h", o, e); end
      end
    end
    n_chk++;
    if (obs_b.size() != 0 || obs_a.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_extra: %0d bytes %0d reads extra, required 0", obs_b.size(), obs_a.size());
    end
    wb_write(2'd1, 32'h2);
  endtask

  task automatic test_backpressure();
    logic [7:0] e, o, held_d;
    logic [3:0] pat;
    bit         held;
    pat = 4'b1001;
    held = 1'b0;
    held_d = 8'd0;
    clear_obs();
    mem[8'h50] = 32'hA4A3A2A1;
    mem[8'h51] = 32'hB4B3B2B1;
    exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    wb_write(2'd2, 32'h50);
    wb_write(2'd3, 32'd2);
    wb_write(2'd0, 32'h1);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      tx_ready = pat[i % 4];
      @(negedge clk);
      if (held) begin
        n_chk++;
        if (tx_valid !== 1'b1 || tx_data !== held_d) begin
          n_fail++;
          $display("FAIL bp_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, held_d);
        end
      end
      held = tx_valid && !tx_ready;
      held_d = tx_data;
      if (obs_b.size() >= 8) break;
    end
    tx_ready = 1'b1;
    wait_idle();
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      n_chk++;
      if (obs_b.size() == 0) begin
        n_fail++; $display("FAIL bp_byte: missing, required %h", e);
      end else begin
        o = obs_b.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL bp_byte: got %h, required %h", o, e); end
      end
    end
    n_chk++;
    if (obs_b.size() != 0) begin
      n_fail++; $display("FAIL bp_extra: %0d bytes extra, required 0", obs_b.size());
    end
    wb_write(2'd1, 32'h2);
  endtask

  task automatic test_abort();
    logic [31:0] r;
    logic [7:0]  e, o;
    clear_obs();
    mem[8'h20] = 32'h5A5B5C5D;
    exp_b = '{8'h5D, 8'h5C};
    exp_a = '{8'h20};
    tx_ready = 1'b0;
    wb_write(2'd2, 32'h20);
    wb_write(2'd3, 32'd4);
    wb_write(2'd0, 32'h1);
    wait_valid("abort");
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 tx_ready = 1'b0;
    wb_write(2'd0, 32'h2);
    @(negedge clk);
    n_chk++;
    if (tx_valid !== 1'b0 || csb !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_outputs: valid=%b csb=%b, required valid=0 csb=1", tx_valid, csb);
    end
    tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    wb_read(2'd1, r);
    n_chk++;
    if (r !== 32'h2) begin n_fail++; $display("FAIL abort_status: got %h, required 00000002", r); end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      n_chk++;
      if (obs_b.size() == 0) begin
        n_fail++; $display("FAIL abort_byte: missing, required %h", e);
      end else begin
        o = obs_b.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL abort_byte: got %h, required %h", o, e); end
      end
    end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_chk++;
      if (obs_a.size() == 0) begin
        n_fail++; $display("FAIL abort_addr: missing, required %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL abort_addr: got %h, required %h", o, e); end
      end
    end
    n_chk++;
    if (obs_b.size() != 0 || obs_a.size() != 0) begin
      n_fail++;
      $display("FAIL abort_extra: %0d bytes %0d reads extra, required 0", obs_b.size(), obs_a.size());
    end
    wb_write(2'd1, 32'h2);
  endtask

  task automatic test_count0_irq();
    logic [31:0] r;
    clear_obs();
    wb_write(2'd3, 32'd0);
    wb_write(2'd0, 32'h5);
    @(negedge clk);
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL cnt0_irq: got %b, required 1", irq); end
    repeat (10) @(posedge clk);
    wb_read(2'd1, r);
    n_chk++;
    if (r !== 32'h2) begin n_fail++; $display("FAIL cnt0_status: got %h, required 00000002", r); end
    n_chk++;
    if (obs_a.size() != 0 || obs_b.size() != 0) begin
      n_fail++;
      $display("FAIL cnt0_activity: %0d reads %0d bytes, required 0 and 0", obs_a.size(), obs_b.size());
    end
    wb_write(2'd1, 32'h2);
    @(negedge clk);
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL cnt0_irq_clear: got %b, required 0", irq); end
    wb_read(2'd0, r);
    n_chk++;
    if (r !== 32'h4) begin n_fail++; $display("FAIL cnt0_ctrl: got %h, required 00000004", r); end
    wb_write(2'd0, 32'h0);
  endtask

  task automatic test_busy_start_reset();
    logic [31:0] r;
    logic [7:0]  e, o;
    clear_obs();
    mem[8'h30] = 32'h13121110;
    mem[8'h31] = 32'h17161514;
    mem[8'h40] = 32'hEEEEEEEE;
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13};
    exp_a = '{8'h30, 8'h31};
    tx_ready = 1'b0;
    wb_write(2'd2, 32'h30);
    wb_write(2'd3, 32'd2);
    wb_write(2'd0, 32'h1);
    wait_valid("busy");
    wb_write(2'd2, 32'h40);
    wb_write(2'd3, 32'd5);
    wb_write(2'd0, 32'h1);
    wb_read(2'd2, r);
    n_chk++;
    if (r !== 32'h40) begin n_fail++; $display("FAIL busy_base_write: got %h, required 00000040", r); end
    @(posedge clk); #1 tx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 tx_ready = 1'b0;
    wait_valid("busy_word1");
    n_chk++;
    if (tx_data !== 8'h14) begin n_fail++; $display("FAIL busy_word1_byte: got %h, required 14", tx_data); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({csb, addr, tx_valid, tx_data, irq, ack, dat_o} !== {1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: csb=%b addr=%h valid=%b data=%h irq=%b ack=%b dat=%h, required csb=1 rest 0",
               csb, addr, tx_valid, tx_data, irq, ack, dat_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    for (int a = 0; a < 4; a++) begin
      wb_read(2'(a), r);
      n_chk++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL midreset_reg%0d: got %h, required 00000000", a, r); end
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      n_chk++;
      if (obs_b.size() == 0) begin
        n_fail++; $display("FAIL busy_byte: missing, required %h", e);
      end else begin
        o = obs_b.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL busy_byte: got %h, required %h", o, e); end
      end
    end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_chk++;
      if (obs_a.size() == 0) begin
        n_fail++; $display("FAIL busy_addr: missing, required %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL busy_addr: got %h, required %h", o, e); end
      end
    end
    n_chk++;
    if (obs_b.size() != 0 || obs_a.size() != 0) begin
      n_fail++;
      $display("FAIL busy_extra: %0d bytes %0d reads extra, required 0", obs_b.size(), obs_a.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | 32'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort();
    test_count0_irq();
    test_busy_start_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
